// File: rtl/cpu_exc_pkg.sv
// Shared exception definitions: flag bit positions, report bits,
// MIPS ExcCode values, default exception vector and commit FSM states.
package cpu_exc_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

    // Raw flag positions in ms_exc = {adel_if, ri, ov, sys, bp, eret, adel_d, ades}
    localparam int RAW_ADEL_IF = 7;
    localparam int RAW_RI      = 6;
    localparam int RAW_OV      = 5;
    localparam int RAW_SYS     = 4;
    localparam int RAW_BP      = 3;
    localparam int RAW_ERET    = 2;
    localparam int RAW_ADEL_D  = 1;
    localparam int RAW_ADES    = 0;

    // One-hot report positions in exc_eret_type = {int, adel, ades, sys, bp, ri, ov, eret}
    localparam int T_INT  = 7;
    localparam int T_ADEL = 6;
    localparam int T_ADES = 5;
    localparam int T_SYS  = 4;
    localparam int T_BP   = 3;
    localparam int T_RI   = 2;
    localparam int T_OV   = 1;
    localparam int T_ERET = 0;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    // Maps a one-hot report vector to the ExcCode CP0 writes into Cause
    function automatic logic [4:0] exc_code(input logic [7:0] onehot);
        logic [4:0] code;
        code = EXCCODE_INT;
        if (onehot[T_ADEL]) code = EXCCODE_ADEL;
        if (onehot[T_ADES]) code = EXCCODE_ADES;
        if (onehot[T_SYS])  code = EXCCODE_SYS;
        if (onehot[T_BP])   code = EXCCODE_BP;
        if (onehot[T_RI])   code = EXCCODE_RI;
        if (onehot[T_OV])   code = EXCCODE_OV;
        return code;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: raw MEM-stage exception flags to a one-hot report
// vector. Interrupts are layered on top by the caller; bit T_INT stays 0.
module exc_prio_enc
    import cpu_exc_pkg::*;
(
    input  logic [7:0] i_exc,
    output logic [7:0] o_onehot
);

    // Pick the single highest-priority flag; eret loses to everything
    always_comb begin
        // NOTE: output is defaulted before the chain so no branch leaves it unassigned (no latch).
        o_onehot = '0;
        if (i_exc[RAW_ADEL_IF])     o_onehot[T_ADEL] = 1'b1;
        else if (i_exc[RAW_RI])     o_onehot[T_RI]   = 1'b1;
        else if (i_exc[RAW_OV])     o_onehot[T_OV]   = 1'b1;
        else if (i_exc[RAW_SYS])    o_onehot[T_SYS]  = 1'b1;
        else if (i_exc[RAW_BP])     o_onehot[T_BP]   = 1'b1;
        else if (i_exc[RAW_ADEL_D]) o_onehot[T_ADEL] = 1'b1;
        else if (i_exc[RAW_ADES])   o_onehot[T_ADES] = 1'b1;
        else if (i_exc[RAW_ERET])   o_onehot[T_ERET] = 1'b1;
    end

endmodule

// File: rtl/exc_commit.sv
// Exception/eret commit unit: accepts one MEM-stage instruction, reports
// the winning exception to CP0, flushes younger stages, then redirects fetch.
module exc_commit
    import cpu_exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          MEM_STAGES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_is_slot,
    input  logic [7:0]  ms_exc,
    input  logic [31:0] ms_data_addr,
    input  logic        int_happen,
    input  logic [31:0] epc,
    output logic [7:0]  exc_eret_type,
    output logic [31:0] cp0_pc,
    output logic        cp0_is_slot,
    output logic [31:0] bad_vaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack
);

    localparam logic [7:0] CNT_INIT = 8'(MEM_STAGES - 1);
    localparam logic [7:0] INT_MASK = 8'(1) << T_INT;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  w_prio;
    logic [7:0]  w_winner;
    logic        w_start;
    logic [7:0]  r_exc_type;
    logic [31:0] r_cp0_pc;
    logic        r_cp0_is_slot;
    logic [31:0] r_bad_vaddr;
    logic [31:0] r_redirect_pc;
    logic        r_is_eret;
    logic [7:0]  r_cnt;

    exc_prio_enc u_prio (
        .i_exc    (ms_exc),
        .o_onehot (w_prio)
    );

    // A pending interrupt overrides every instruction-raised flag
    assign w_winner = int_happen ? INT_MASK : w_prio;
    assign w_start  = ms_valid && (r_state == ST_IDLE) && (w_winner != 8'd0);

    assign exc_eret_type = r_exc_type;
    assign cp0_pc        = r_cp0_pc;
    assign cp0_is_slot   = r_cp0_is_slot;
    assign bad_vaddr     = r_bad_vaddr;
    assign redirect_pc   = r_redirect_pc;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_nxt    = r_state;
        ws_allowin     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ws_allowin = 1'b1;
                if (w_start) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                flush       = 1'b1;
                w_state_nxt = (MEM_STAGES > 1) ? ST_FLUSH : ST_REDIRECT;
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (r_cnt <= 8'd1) w_state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the committing instruction, pulse CP0, count flush, latch target
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exc_type    <= '0;
            r_cp0_pc      <= '0;
            r_cp0_is_slot <= 1'b0;
            r_bad_vaddr   <= '0;
            r_redirect_pc <= '0;
            r_is_eret     <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_exc_type <= w_start ? w_winner : 8'd0;
            if (w_start) begin
                r_cp0_pc      <= ms_pc;
                r_cp0_is_slot <= ms_is_slot;
                r_is_eret     <= w_winner[T_ERET];
                r_cnt         <= CNT_INIT;
                if (w_winner[T_ADEL])
                    r_bad_vaddr <= ms_exc[RAW_ADEL_IF] ? ms_pc : ms_data_addr;
                else if (w_winner[T_ADES])
                    r_bad_vaddr <= ms_data_addr;
            end else if (r_state == ST_FLUSH) begin
                r_cnt <= r_cnt - 8'd1;
            end
            // Target is fixed on entry so it stays stable until fetch acks
            if (r_state != ST_REDIRECT && w_state_nxt == ST_REDIRECT)
                r_redirect_pc <= r_is_eret ? epc : EXC_VECTOR;
            else if (r_state == ST_REDIRECT && w_state_nxt == ST_IDLE)
                r_redirect_pc <= '0;
        end
    end

endmodule

// File: tb/tb_exc_commit.sv
// Self-checking bench: two exc_commit instances (MEM_STAGES 1 and 3) driven
// by shared stimulus, each checked every cycle against a transaction model.
module tb_exc_commit;

    localparam logic [31:0] VEC = 32'hBFC00380;
    // Priority order of raw flag positions and the report bit each maps to
    localparam int RAW_ORDER [8] = '{7, 6, 5, 4, 3, 1, 0, 2};
    localparam int OUT_BIT   [8] = '{6, 2, 1, 4, 3, 6, 5, 0};

    typedef struct {
        int          flush_left;
        bit          redir;
        logic [7:0]  pulse;
        logic [31:0] cp0_pc;
        logic        slot;
        logic [31:0] bad;
        logic [31:0] rpc;
        bit          eret;
    } model_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ms_valid = 1'b0;
    logic [31:0] ms_pc = '0;
    logic        ms_is_slot = 1'b0;
    logic [7:0]  ms_exc = '0;
    logic [31:0] ms_data_addr = '0;
    logic        int_happen = 1'b0;
    logic [31:0] epc = '0;
    logic        redirect_ack = 1'b0;

    logic        d1_allow, d1_flush, d1_rv, d1_slot;
    logic [7:0]  d1_type;
    logic [31:0] d1_cpc, d1_bad, d1_rpc;
    logic        d3_allow, d3_flush, d3_rv, d3_slot;
    logic [7:0]  d3_type;
    logic [31:0] d3_cpc, d3_bad, d3_rpc;

    int n_cmp = 0;
    int n_err = 0;
    model_t m1, m3;

    always #5 clk = ~clk;

    exc_commit #(.EXC_VECTOR(VEC), .MEM_STAGES(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .ms_valid(ms_valid), .ws_allowin(d1_allow),
        .ms_pc(ms_pc), .ms_is_slot(ms_is_slot), .ms_exc(ms_exc), .ms_data_addr(ms_data_addr),
        .int_happen(int_happen), .epc(epc), .exc_eret_type(d1_type), .cp0_pc(d1_cpc),
        .cp0_is_slot(d1_slot), .bad_vaddr(d1_bad), .flush(d1_flush), .redirect_valid(d1_rv),
        .redirect_pc(d1_rpc), .redirect_ack(redirect_ack)
    );

    exc_commit #(.EXC_VECTOR(VEC), .MEM_STAGES(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .ms_valid(ms_valid), .ws_allowin(d3_allow),
        .ms_pc(ms_pc), .ms_is_slot(ms_is_slot), .ms_exc(ms_exc), .ms_data_addr(ms_data_addr),
        .int_happen(int_happen), .epc(epc), .exc_eret_type(d3_type), .cp0_pc(d3_cpc),
        .cp0_is_slot(d3_slot), .bad_vaddr(d3_bad), .flush(d3_flush), .redirect_valid(d3_rv),
        .redirect_pc(d3_rpc), .redirect_ack(redirect_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner by walking the priority list; rb is the raw flag that won (-1 if none/int)
    function automatic void prio(input logic intr, input logic [7:0] exc,
                                 output logic [7:0] w, output int rb);
        w  = 8'h00;
        rb = -1;
        if (intr) begin
            w = 8'h80;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (exc[RAW_ORDER[i]]) begin
                    w[OUT_BIT[i]] = 1'b1;
                    rb = RAW_ORDER[i];
                    break;
                end
            end
        end
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m = '{default: '0};
        return m;
    endfunction

    function automatic bit is_idle(input model_t m);
        return (m.flush_left == 0) && !m.redir;
    endfunction

    // One clock of the transaction model: accept, count flush cycles, redirect until ack
    function automatic model_t step(input model_t m, input int stages);
        model_t     n;
        logic [7:0] w;
        int         rb;
        n       = m;
        n.pulse = 8'h00;
        if (is_idle(m)) begin
            if (ms_valid) begin
                prio(int_happen, ms_exc, w, rb);
                if (w != 8'h00) begin
                    n.pulse      = w;
                    n.flush_left = stages;
                    n.eret       = (w == 8'h01);
                    n.cp0_pc     = ms_pc;
                    n.slot       = ms_is_slot;
                    if (rb == 7) n.bad = ms_pc;
                    else if (rb == 1 || rb == 0) n.bad = ms_data_addr;
                end
            end
        end else if (m.flush_left > 0) begin
            n.flush_left = m.flush_left - 1;
            if (n.flush_left == 0) begin
                n.redir = 1'b1;
                n.rpc   = m.eret ? epc : VEC;
            end
        end else if (redirect_ack) begin
            n.redir = 1'b0;
            n.rpc   = '0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m1 <= model_reset();
            m3 <= model_reset();
        end else begin
            m1 <= step(m1, 1);
            m3 <= step(m3, 3);
        end
    end

    task automatic compare_one(input string t, input model_t m, input logic allow,
                               input logic fl, input logic rv, input logic [31:0] rpc,
                               input logic [7:0] typ, input logic [31:0] cpc,
                               input logic slot, input logic [31:0] bad);
        check({t, ".ws_allowin"}, 32'(allow), 32'(is_idle(m)));
        check({t, ".flush"}, 32'(fl), 32'(m.flush_left > 0));
        check({t, ".redirect_valid"}, 32'(rv), 32'(m.redir));
        check({t, ".redirect_pc"}, rpc, m.redir ? m.rpc : 32'h0);
        check({t, ".exc_eret_type"}, 32'(typ), 32'(m.pulse));
        check({t, ".cp0_pc"}, cpc, m.cp0_pc);
        check({t, ".cp0_is_slot"}, 32'(slot), 32'(m.slot));
        check({t, ".bad_vaddr"}, bad, m.bad);
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (resetn) begin
            compare_one("ms1", m1, d1_allow, d1_flush, d1_rv, d1_rpc, d1_type, d1_cpc, d1_slot, d1_bad);
            compare_one("ms3", m3, d3_allow, d3_flush, d3_rv, d3_rpc, d3_type, d3_cpc, d3_slot, d3_bad);
        end
    end

    // Called at negedge+1; leaves inputs quiet with the instruction accepted at the next edge
    task automatic present(input logic [7:0] exc, input logic [31:0] pc, input logic [31:0] addr,
                           input logic slot, input logic intr);
        ms_valid     = 1'b1;
        ms_exc       = exc;
        ms_pc        = pc;
        ms_data_addr = addr;
        ms_is_slot   = slot;
        int_happen   = intr;
        @(posedge clk);
        #1;
        ms_valid   = 1'b0;
        ms_exc     = 8'h00;
        int_happen = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok           = 1'b0;
        ms_valid     = 1'b0;
        redirect_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_idle(m1) && is_idle(m3)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 32'(ok), 32'd1);
        #1;
        redirect_ack = 1'b0;
    endtask

    function automatic logic [7:0] gen_exc();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 8'h00;
        if (r < 8) return 8'(1) << $urandom_range(0, 7);
        return (8'(1) << $urandom_range(0, 7)) | (8'(1) << $urandom_range(0, 7));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c1, c3;
        bit done1, done3;

        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst.ws_allowin", 32'(d1_allow), 32'd1);
        check("rst.exc_eret_type", 32'(d1_type), 32'h0);
        check("rst.flush", 32'(d1_flush), 32'd0);
        check("rst.redirect_valid", 32'(d1_rv), 32'd0);
        check("rst.redirect_pc", d1_rpc, 32'h0);
        check("rst.cp0_pc", d1_cpc, 32'h0);
        check("rst.bad_vaddr", d1_bad, 32'h0);
        wait_idle();

        // Overflow: vector redirect held until ack
        present(8'h20, 32'h80001000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("ov.type", 32'(d1_type), 32'h02);
        check("ov.cp0_pc", d1_cpc, 32'h80001000);
        check("ov.slot", 32'(d1_slot), 32'd0);
        check("ov.flush", 32'(d1_flush), 32'd1);
        @(negedge clk);
        check("ov.rv", 32'(d1_rv), 32'd1);
        check("ov.rpc", d1_rpc, 32'hBFC00380);
        check("ov.type_clear", 32'(d1_type), 32'h0);
        @(negedge clk);
        check("ov.rpc_hold", d1_rpc, 32'hBFC00380);
        #1 redirect_ack = 1'b1;
        @(negedge clk);
        check("ov.rv_after_ack", 32'(d1_rv), 32'd0);
        wait_idle();

        // adel_d|ov reports ov only; adel_d alone updates bad_vaddr
        present(8'h22, 32'h80000100, 32'h80000003, 1'b1, 1'b0);
        @(negedge clk);
        check("adov.type", 32'(d1_type), 32'h02);
        check("adov.bad", d1_bad, 32'h0);
        check("adov.slot", 32'(d1_slot), 32'd1);
        wait_idle();
        present(8'h02, 32'h80000104, 32'h80000003, 1'b0, 1'b0);
        @(negedge clk);
        check("adel.type", 32'(d1_type), 32'h40);
        check("adel.bad", d1_bad, 32'h80000003);
        wait_idle();

        // Interrupt beats syscall; bad_vaddr held
        present(8'h10, 32'h80000200, 32'h12345678, 1'b0, 1'b1);
        @(negedge clk);
        check("int.type", 32'(d1_type), 32'h80);
        check("int.bad_held", d1_bad, 32'h80000003);
        wait_idle();

        // eret: redirect to epc, held while ack stays low, new instructions ignored
        epc = 32'h80002000;
        present(8'h04, 32'h80000300, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("eret.type", 32'(d1_type), 32'h01);
        @(posedge clk);
        #1;
        ms_valid = 1'b1;
        ms_exc   = 8'h20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("eret.rv", 32'(d1_rv), 32'd1);
            check("eret.rpc", d1_rpc, 32'h80002000);
            check("eret.allowin", 32'(d1_allow), 32'd0);
            check("eret.no_pulse", 32'(d1_type), 32'h0);
        end
        #1;
        ms_valid     = 1'b0;
        ms_exc       = 8'h00;
        redirect_ack = 1'b1;
        @(negedge clk);
        check("eret.rv_after_ack", 32'(d1_rv), 32'd0);
        check("eret.rpc_after_ack", d1_rpc, 32'h0);
        wait_idle();

        // Flush length equals MEM_STAGES
        present(8'h40, 32'h80000400, 32'h0, 1'b0, 1'b0);
        c1 = 0; c3 = 0; done1 = 1'b0; done3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            if (!done1) begin
                if (d1_rv) done1 = 1'b1;
                else if (d1_flush) c1++;
            end
            if (!done3) begin
                if (d3_rv) done3 = 1'b1;
                else if (d3_flush) c3++;
            end
            if (done1 && done3) break;
        end
        check("flush_len.ms1", 32'(c1), 32'd1);
        check("flush_len.ms3", 32'(c3), 32'd3);
        check("flush_len.reached", 32'(done1 && done3), 32'd1);
        wait_idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            ms_valid     = $urandom_range(0, 1);
            ms_exc       = gen_exc();
            ms_pc        = $urandom;
            ms_data_addr = $urandom;
            ms_is_slot   = $urandom_range(0, 1);
            int_happen   = ($urandom_range(0, 99) < 15);
            redirect_ack = ($urandom_range(0, 99) < 35);
            if (is_idle(m1) && is_idle(m3)) epc = $urandom;
        end
        ms_valid   = 1'b0;
        int_happen = 1'b0;
        wait_idle();

        // Reset during REDIRECT abandons the sequence
        present(8'h10, 32'h80000500, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.rv_before", 32'(d1_rv), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid.rv", 32'(d1_rv), 32'd0);
        check("rst_mid.rpc", d1_rpc, 32'h0);
        check("rst_mid.flush", 32'(d1_flush), 32'd0);
        check("rst_mid.type", 32'(d1_type), 32'h0);
        check("rst_mid.cp0_pc", d1_cpc, 32'h0);
        check("rst_mid.slot", 32'(d1_slot), 32'd0);
        check("rst_mid.ms3_flush", 32'(d3_flush), 32'd0);
        @(negedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid.allowin", 32'(d1_allow), 32'd1);
            check("rst_mid.no_pulse", 32'(d1_type | d3_type), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
